// File: rtl/l1_mem_port_arbiter_pkg.sv
// Shared definitions for the L1 data/instruction cache memory port arbiter.
package l1_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    L_PARAM_IDLE     = 2'd0,
    L_PARAM_GRANT_S0 = 2'd1,
    L_PARAM_GRANT_S1 = 2'd2
  } arb_state_e;

  localparam logic L_OWNER_DATA = 1'b0;
  localparam logic L_OWNER_INST = 1'b1;

endpackage

// File: rtl/l1_mem_port_arbiter_tag_fifo.sv
// In-order owner-tag FIFO: one bit per accepted beat, head read combinationally.
module l1_mem_port_arbiter_tag_fifo #(
  parameter int P_DEPTH = 16
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int L_AW = $clog2(P_DEPTH);

  logic [L_AW:0]      wptr_q;
  logic [L_AW:0]      rptr_q;
  logic [P_DEPTH-1:0] mem_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge iCLOCK) begin
    if (push_i) mem_q[wptr_q[L_AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rptr_q[L_AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[L_AW] != rptr_q[L_AW]) &&
                   (wptr_q[L_AW-1:0] == rptr_q[L_AW-1:0]);

endmodule

// File: rtl/l1_mem_port_arbiter.sv
// Two-port (D-cache S0 / I-cache S1) arbiter for the shared memory request port.
// Optional perf counters: define L1_MEM_ARB_PERF_COUNTER_EN.
module l1_mem_port_arbiter
  import l1_mem_port_arbiter_pkg::*;
#(
  parameter int P_OUTSTANDING = 16,
  parameter int P_BURST_MAX   = 8
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iS0_REQ,
  output logic        oS0_LOCK,
  input  logic [1:0]  iS0_ORDER,
  input  logic        iS0_RW,
  input  logic [13:0] iS0_TID,
  input  logic [1:0]  iS0_MMUMOD,
  input  logic [31:0] iS0_PDT,
  input  logic [31:0] iS0_ADDR,
  input  logic [31:0] iS0_DATA,
  output logic        oS0_VALID,
  output logic        oS0_PAGEFAULT,
  output logic [27:0] oS0_MMU_FLAGS,
  output logic [63:0] oS0_DATA,
  input  logic        iS1_REQ,
  output logic        oS1_LOCK,
  input  logic [1:0]  iS1_ORDER,
  input  logic        iS1_RW,
  input  logic [13:0] iS1_TID,
  input  logic [1:0]  iS1_MMUMOD,
  input  logic [31:0] iS1_PDT,
  input  logic [31:0] iS1_ADDR,
  input  logic [31:0] iS1_DATA,
  output logic        oS1_VALID,
  output logic        oS1_PAGEFAULT,
  output logic [27:0] oS1_MMU_FLAGS,
  output logic [63:0] oS1_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [1:0]  oMEM_ORDER,
  output logic        oMEM_RW,
  output logic [13:0] oMEM_TID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic        iMEM_PAGEFAULT,
  input  logic [27:0] iMEM_MMU_FLAGS,
  input  logic [63:0] iMEM_DATA,
`ifdef L1_MEM_ARB_PERF_COUNTER_EN
  output logic [31:0] oPERF_GRANT_S0,
  output logic [31:0] oPERF_GRANT_S1,
  output logic [31:0] oPERF_CONFLICT,
`endif
  output logic        oERR_ORPHAN
);

  localparam logic [3:0] L_BURST = 4'(P_BURST_MAX);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic [3:0] beat_q, beat_d;
  logic       orphan_q;

  logic       grant0, grant1, own_req, oth_req;
  logic       fifo_full_raw, fifo_empty, fifo_full, fifo_head;
  logic       pop, accept, at_limit;
  logic [3:0] beat_inc;

  assign grant0   = (state_q == L_PARAM_GRANT_S0);
  assign grant1   = (state_q == L_PARAM_GRANT_S1);
  assign own_req  = grant0 ? iS0_REQ : (grant1 ? iS1_REQ : 1'b0);
  assign oth_req  = grant0 ? iS1_REQ : (grant1 ? iS0_REQ : 1'b0);

  // A response popping a full FIFO frees its slot for a beat in the same cycle.
  assign pop       = iMEM_VALID && !fifo_empty;
  assign fifo_full = fifo_full_raw && !pop;

  assign oMEM_REQ = own_req && !fifo_full;
  assign accept   = oMEM_REQ && !iMEM_LOCK;
  assign beat_inc = beat_q + 4'd1;
  assign at_limit = accept && (beat_inc == L_BURST);

  assign oS0_LOCK = !grant0 || iMEM_LOCK || fifo_full;
  assign oS1_LOCK = !grant1 || iMEM_LOCK || fifo_full;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q  <= L_PARAM_IDLE;
      rr_q     <= 1'b0;
      beat_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      if (iMEM_VALID && fifo_empty) orphan_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    unique case (state_q)
      L_PARAM_IDLE: begin
        if (iS0_REQ && iS1_REQ) state_d = rr_q ? L_PARAM_GRANT_S1 : L_PARAM_GRANT_S0;
        else if (iS0_REQ)       state_d = L_PARAM_GRANT_S0;
        else if (iS1_REQ)       state_d = L_PARAM_GRANT_S1;
      end
      L_PARAM_GRANT_S0, L_PARAM_GRANT_S1: begin
        if (accept) beat_d = beat_inc;
        if (!own_req || (at_limit && oth_req)) begin
          state_d = !oth_req ? L_PARAM_IDLE :
                    (grant0 ? L_PARAM_GRANT_S1 : L_PARAM_GRANT_S0);
          rr_d    = grant0;
          beat_d  = '0;
        end else if (at_limit) begin
          beat_d  = '0;
        end
      end
      default: state_d = L_PARAM_IDLE;
    endcase
  end

  always_comb begin
    oMEM_ORDER  = '0;
    oMEM_RW     = 1'b0;
    oMEM_TID    = '0;
    oMEM_MMUMOD = '0;
    oMEM_PDT    = '0;
    oMEM_ADDR   = '0;
    oMEM_DATA   = '0;
    if (grant0) begin
      oMEM_ORDER  = iS0_ORDER;
      oMEM_RW     = iS0_RW;
      oMEM_TID    = iS0_TID;
      oMEM_MMUMOD = iS0_MMUMOD;
      oMEM_PDT    = iS0_PDT;
      oMEM_ADDR   = iS0_ADDR;
      oMEM_DATA   = iS0_DATA;
    end else if (grant1) begin
      oMEM_ORDER  = iS1_ORDER;
      oMEM_RW     = iS1_RW;
      oMEM_TID    = iS1_TID;
      oMEM_MMUMOD = iS1_MMUMOD;
      oMEM_PDT    = iS1_PDT;
      oMEM_ADDR   = iS1_ADDR;
      oMEM_DATA   = iS1_DATA;
    end
  end

  l1_mem_port_arbiter_tag_fifo #(.P_DEPTH(P_OUTSTANDING)) u_tag_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .push_i  (accept),
    .data_i  (grant1 ? L_OWNER_INST : L_OWNER_DATA),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full_raw),
    .empty_o (fifo_empty)
  );

  // Only VALID is steered; response payload is shared by both caches.
  assign oS0_VALID     = pop && (fifo_head == L_OWNER_DATA);
  assign oS1_VALID     = pop && (fifo_head == L_OWNER_INST);
  assign oS0_PAGEFAULT = iMEM_PAGEFAULT;
  assign oS1_PAGEFAULT = iMEM_PAGEFAULT;
  assign oS0_MMU_FLAGS = iMEM_MMU_FLAGS;
  assign oS1_MMU_FLAGS = iMEM_MMU_FLAGS;
  assign oS0_DATA      = iMEM_DATA;
  assign oS1_DATA      = iMEM_DATA;
  assign oERR_ORPHAN   = orphan_q;

`ifdef L1_MEM_ARB_PERF_COUNTER_EN
  logic [31:0] perf_g0_q, perf_g1_q, perf_cf_q;
  logic        conflict;

  assign conflict = (state_q == L_PARAM_IDLE) ? (iS0_REQ && iS1_REQ) : oth_req;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      perf_g0_q <= '0;
      perf_g1_q <= '0;
      perf_cf_q <= '0;
    end else begin
      if (accept && grant0) perf_g0_q <= perf_g0_q + 32'd1;
      if (accept && grant1) perf_g1_q <= perf_g1_q + 32'd1;
      if (conflict)         perf_cf_q <= perf_cf_q + 32'd1;
    end
  end

  assign oPERF_GRANT_S0 = perf_g0_q;
  assign oPERF_GRANT_S1 = perf_g1_q;
  assign oPERF_CONFLICT = perf_cf_q;
`endif

endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
// Bench for l1_mem_port_arbiter: queue-based reference model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_l1_mem_port_arbiter;

  localparam int P_OUT   = 16;
  localparam int P_BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s0_req, s1_req, s0_rw, s1_rw;
  logic [1:0]  s0_order, s1_order, s0_mmu, s1_mmu;
  logic [13:0] s0_tid, s1_tid;
  logic [31:0] s0_pdt, s1_pdt, s0_addr, s1_addr, s0_data, s1_data;
  logic        mem_lock, mem_valid, mem_pf;
  logic [27:0] mem_flags;
  logic [63:0] mem_data;

  logic        oS0_LOCK, oS0_VALID, oS0_PAGEFAULT, oS1_LOCK, oS1_VALID, oS1_PAGEFAULT;
  logic [27:0] oS0_MMU_FLAGS, oS1_MMU_FLAGS;
  logic [63:0] oS0_DATA, oS1_DATA;
  logic        oMEM_REQ, oMEM_RW, oERR_ORPHAN;
  logic [1:0]  oMEM_ORDER, oMEM_MMUMOD;
  logic [13:0] oMEM_TID;
  logic [31:0] oMEM_PDT, oMEM_ADDR, oMEM_DATA;
`ifdef L1_MEM_ARB_PERF_COUNTER_EN
  logic [31:0] perf_g0, perf_g1, perf_cf;
`endif

  l1_mem_port_arbiter #(.P_OUTSTANDING(P_OUT), .P_BURST_MAX(P_BURST)) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iS0_REQ(s0_req), .oS0_LOCK(oS0_LOCK), .iS0_ORDER(s0_order), .iS0_RW(s0_rw),
    .iS0_TID(s0_tid), .iS0_MMUMOD(s0_mmu), .iS0_PDT(s0_pdt), .iS0_ADDR(s0_addr),
    .iS0_DATA(s0_data), .oS0_VALID(oS0_VALID), .oS0_PAGEFAULT(oS0_PAGEFAULT),
    .oS0_MMU_FLAGS(oS0_MMU_FLAGS), .oS0_DATA(oS0_DATA),
    .iS1_REQ(s1_req), .oS1_LOCK(oS1_LOCK), .iS1_ORDER(s1_order), .iS1_RW(s1_rw),
    .iS1_TID(s1_tid), .iS1_MMUMOD(s1_mmu), .iS1_PDT(s1_pdt), .iS1_ADDR(s1_addr),
    .iS1_DATA(s1_data), .oS1_VALID(oS1_VALID), .oS1_PAGEFAULT(oS1_PAGEFAULT),
    .oS1_MMU_FLAGS(oS1_MMU_FLAGS), .oS1_DATA(oS1_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(mem_lock), .oMEM_ORDER(oMEM_ORDER), .oMEM_RW(oMEM_RW),
    .oMEM_TID(oMEM_TID), .oMEM_MMUMOD(oMEM_MMUMOD), .oMEM_PDT(oMEM_PDT),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(mem_valid), .iMEM_PAGEFAULT(mem_pf), .iMEM_MMU_FLAGS(mem_flags),
    .iMEM_DATA(mem_data),
`ifdef L1_MEM_ARB_PERF_COUNTER_EN
    .oPERF_GRANT_S0(perf_g0), .oPERF_GRANT_S1(perf_g1), .oPERF_CONFLICT(perf_cf),
`endif
    .oERR_ORPHAN(oERR_ORPHAN)
  );

  int checks = 0;
  int errors = 0;

  // Requesters: each has a count of beats still to send and beats already sent.
  int n0_left, n0_done, n1_left, n1_done;
  bit auto_resp;

  // Reference model: owner 0 = none, 1 = S0, 2 = S1; tags kept in a queue.
  int  m_owner, m_rr, m_beats, cyc;
  bit  m_q[$];
  bit  m_orph, m_acc0, m_acc1;
  int  acc_own[$];
  int  acc_cyc[$];
  int  rsp_own[$];
  logic [31:0] acc_addr[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out (t=%0t)", nm, $time);
  endtask

  task automatic drive();
    s0_req   = (n0_left > 0);
    s0_addr  = 32'h1000 + 32'(n0_done * 4);
    s0_data  = 32'hD000_0000 + 32'(n0_done);
    s0_tid   = 14'(32'h0A0 + n0_done);
    s0_rw    = n0_done[0];
    s0_order = 2'd1;
    s0_mmu   = 2'd1;
    s0_pdt   = 32'hAAAA_0000;
    s1_req   = (n1_left > 0);
    s1_addr  = 32'h2000 + 32'(n1_done * 4);
    s1_data  = 32'hE000_0000 + 32'(n1_done);
    s1_tid   = 14'(32'h150 + n1_done);
    s1_rw    = 1'b1;
    s1_order = 2'd2;
    s1_mmu   = 2'd2;
    s1_pdt   = 32'hBBBB_0000;
  endtask

  task automatic model_cycle();
    bit full, popv, eff_full, own, oth, e_req, acc, e_v0, e_v1;
    logic [114:0] e_pay;
    int other;
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    if (!rst_n) begin
      m_owner = 0; m_rr = 0; m_beats = 0; m_orph = 1'b0;
      m_q.delete();
    end
    full     = (m_q.size() == P_OUT);
    popv     = rst_n && mem_valid && (m_q.size() > 0);
    eff_full = full && !popv;
    own      = (m_owner == 1) ? s0_req : ((m_owner == 2) ? s1_req : 1'b0);
    oth      = (m_owner == 1) ? s1_req : ((m_owner == 2) ? s0_req : 1'b0);
    e_req    = own && !eff_full;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (popv) begin
      e_v0 = (m_q[0] == 1'b0);
      e_v1 = (m_q[0] == 1'b1);
    end
    if (m_owner == 1)      e_pay = {s0_order, s0_rw, s0_tid, s0_mmu, s0_pdt, s0_addr, s0_data};
    else if (m_owner == 2) e_pay = {s1_order, s1_rw, s1_tid, s1_mmu, s1_pdt, s1_addr, s1_data};
    else                   e_pay = '0;

    chk("mem_req", oMEM_REQ, e_req);
    chk("s0_lock", oS0_LOCK, (m_owner != 1) || mem_lock || eff_full);
    chk("s1_lock", oS1_LOCK, (m_owner != 2) || mem_lock || eff_full);
    chk("s0_valid", oS0_VALID, e_v0);
    chk("s1_valid", oS1_VALID, e_v1);
    chk("orphan", oERR_ORPHAN, m_orph);
    chk("payload", {oMEM_ORDER, oMEM_RW, oMEM_TID, oMEM_MMUMOD, oMEM_PDT, oMEM_ADDR, oMEM_DATA}, e_pay);
    chk("rsp_bcast", {oS0_PAGEFAULT, oS0_MMU_FLAGS, oS0_DATA, oS1_PAGEFAULT, oS1_MMU_FLAGS, oS1_DATA},
        {mem_pf, mem_flags, mem_data, mem_pf, mem_flags, mem_data});
    if (!rst_n) return;

    acc = e_req && !mem_lock;
    if (popv) begin
      rsp_own.push_back(int'(m_q[0]));
      void'(m_q.pop_front());
    end else if (mem_valid) begin
      m_orph = 1'b1;
    end
    if (acc) begin
      m_q.push_back(m_owner == 2);
      acc_own.push_back(m_owner - 1);
      acc_addr.push_back(e_pay[63:32]);
      acc_cyc.push_back(cyc);
      if (m_owner == 1) m_acc0 = 1'b1;
      else              m_acc1 = 1'b1;
      m_beats++;
    end
    if (m_owner == 0) begin
      if (s0_req && s1_req) m_owner = (m_rr == 1) ? 2 : 1;
      else if (s0_req)      m_owner = 1;
      else if (s1_req)      m_owner = 2;
    end else if (!own || (m_beats == P_BURST && oth)) begin
      other   = 3 - m_owner;
      m_rr    = (other == 2) ? 1 : 0;
      m_owner = oth ? other : 0;
      m_beats = 0;
    end else if (m_beats == P_BURST) begin
      m_beats = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      model_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (m_acc0) begin n0_left--; n0_done++; end
    if (m_acc1) begin n1_left--; n1_done++; end
    if (auto_resp) mem_valid = (m_q.size() > 0);
    mem_pf    = $urandom_range(0, 1) == 1;
    mem_flags = 28'($urandom);
    mem_data  = {$urandom, $urandom};
    drive();
  endtask

  task automatic look();
    #5;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    n0_left = 0; n0_done = 0; n1_left = 0; n1_done = 0;
    mem_valid = 1'b0; mem_lock = 1'b0; auto_resp = 1'b0;
    mem_pf = 1'b0; mem_flags = '0; mem_data = '0;
    drive();
    step();
    step();
    rst_n = 1'b1;
    acc_own.delete(); acc_addr.delete(); acc_cyc.delete(); rsp_own.delete();
  endtask

  task automatic wait_acc(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (acc_own.size() < n && k < budget) begin step(); k++; end
    if (acc_own.size() < n) timeout(nm);
  endtask

  task automatic wait_rsp(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (rsp_own.size() < n && k < budget) begin step(); k++; end
    if (rsp_own.size() < n) timeout(nm);
  endtask

  initial begin
    int c0;
    int zeros;
    logic [31:0] pat;

    // Reset values
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_s0_lock", oS0_LOCK, 1'b1);
    chk("rst_s1_lock", oS1_LOCK, 1'b1);
    chk("rst_mem_req", oMEM_REQ, 1'b0);
    chk("rst_orphan", oERR_ORPHAN, 1'b0);
    chk("rst_addr", oMEM_ADDR, 32'h0);
    do_reset();

    // Single S0 burst of 8 beats
    n0_left = 8;
    drive();
    look();
    c0 = cyc;
    chk("idle_no_req", oMEM_REQ, 1'b0);
    wait_acc(8, 40, "single_acc");
    if (acc_own.size() >= 8) begin
      chk("single_lat", acc_cyc[0], c0 + 1);
      chk("single_b2b", acc_cyc[7] - acc_cyc[0], 7);
      for (int i = 0; i < 8; i++) chk("single_addr", acc_addr[i], 32'h1000 + 32'(4 * i));
    end
    auto_resp = 1'b1;
    wait_rsp(8, 40, "single_rsp");
    zeros = 0;
    foreach (rsp_own[i]) if (rsp_own[i] == 0) zeros++;
    chk("single_rsp_s0", zeros, 8);
    chk("single_rsp_cnt", rsp_own.size(), 8);

    // Contention from reset
    do_reset();
    n0_left = 16;
    n1_left = 16;
    auto_resp = 1'b1;
    drive();
    wait_acc(32, 120, "cont_acc");
    if (acc_own.size() >= 32) begin
      pat = '0;
      for (int i = 0; i < 32; i++) pat[i] = acc_own[i][0];
      chk("cont_grant_order", pat, 32'hFF00_FF00);
      chk("cont_gap_1", acc_cyc[8] - acc_cyc[7], 1);
      chk("cont_gap_2", acc_cyc[16] - acc_cyc[15], 1);
    end
    wait_rsp(32, 40, "cont_rsp");
    if (rsp_own.size() >= 32) begin
      pat = '0;
      for (int i = 0; i < 32; i++) pat[i] = rsp_own[i][0];
      chk("cont_rsp_order", pat, 32'hFF00_FF00);
    end

    // Memory lock during S1 grant
    do_reset();
    n1_left = 6;
    drive();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      mem_lock = 1'b1;
      look();
      chk("lock_s1_lock", oS1_LOCK, 1'b1);
    end
    chk("lock_no_push", acc_own.size(), 2);
    step();
    mem_lock = 1'b0;
    wait_acc(6, 30, "lock_acc");
    repeat (3) step();
    chk("lock_total", acc_own.size(), 6);
    if (acc_own.size() >= 6)
      for (int i = 0; i < 6; i++) chk("lock_addr", acc_addr[i], 32'h2000 + 32'(4 * i));

    // FIFO full, then pop and push in one cycle
    do_reset();
    n0_left = 20;
    drive();
    repeat (20) step();
    look();
    chk("full_mem_req", oMEM_REQ, 1'b0);
    chk("full_s0_lock", oS0_LOCK, 1'b1);
    chk("full_acc_cnt", acc_own.size(), 16);
    step();
    mem_valid = 1'b1;
    look();
    chk("full_pop_req", oMEM_REQ, 1'b1);
    chk("full_pop_valid", oS0_VALID, 1'b1);
    step();
    mem_valid = 1'b0;
    look();
    chk("full_acc_after", acc_own.size(), 17);
    chk("full_again", oMEM_REQ, 1'b0);

    // Orphan response
    do_reset();
    step();
    mem_valid = 1'b1;
    look();
    chk("orph_no_v0", oS0_VALID, 1'b0);
    chk("orph_no_v1", oS1_VALID, 1'b0);
    step();
    mem_valid = 1'b0;
    look();
    chk("orph_set", oERR_ORPHAN, 1'b1);
    repeat (5) step();
    chk("orph_sticky", oERR_ORPHAN, 1'b1);

    // Reset in the middle of a burst
    do_reset();
    chk("orph_cleared", oERR_ORPHAN, 1'b0);
    n0_left = 8;
    drive();
    wait_acc(3, 20, "mid_acc");
    rst_n = 1'b0;
    #1;
    chk("mid_s0_lock", oS0_LOCK, 1'b1);
    chk("mid_mem_req", oMEM_REQ, 1'b0);
    chk("mid_addr", oMEM_ADDR, 32'h0);
    n0_left = 0;
    drive();
    step();
    step();
    rst_n = 1'b1;
    step();
    mem_valid = 1'b1;
    look();
    chk("mid_no_valid", oS0_VALID, 1'b0);
    step();
    mem_valid = 1'b0;
    look();
    chk("mid_orphan", oERR_ORPHAN, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_port_arbiter.md
Name: l1_mem_port_arbiter

Overview:
- Shares the single data-memory request port between the L1 data cache (port S0) and the L1 instruction cache (port S1).
- Grants one requester at a time and holds the grant across multi-beat line fills. Records the owner of every accepted beat in an in-order tag FIFO, and routes each memory response back to the requester that issued it.
- Sits between both L1 caches and the MMU/memory interface.

Parameters:
- P_OUTSTANDING, 16, depth of the owner-tag FIFO (max accepted-but-unanswered beats, power of 2).
- P_BURST_MAX, 8, max beats accepted per grant before yielding to a waiting requester.

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  asynchronous active-low reset.
- iSx_REQ  in  1  request from requester x; x = 0 is the data cache, x = 1 is the instruction cache.
- oSx_LOCK  out  1  beat not accepted this cycle; requester must hold REQ and payload.
- iSx_ORDER  in  2  access order.
- iSx_RW  in  1  0 = write, 1 = read.
- iSx_TID  in  14  task ID.
- iSx_MMUMOD  in  2  MMU mode.
- iSx_PDT  in  32  page directory table base.
- iSx_ADDR  in  32  address.
- iSx_DATA  in  32  write data.
- oSx_VALID  out  1  response for requester x.
- oSx_PAGEFAULT  out  1  response pagefault.
- oSx_MMU_FLAGS  out  28  response MMU flags.
- oSx_DATA  out  64  response data.
- oMEM_REQ  out  1  request to memory.
- iMEM_LOCK  in  1  memory cannot accept.
- oMEM_ORDER  out  2  muxed from owner.
- oMEM_RW  out  1  muxed from owner.
- oMEM_TID  out  14  muxed from owner.
- oMEM_MMUMOD  out  2  muxed from owner.
- oMEM_PDT  out  32  muxed from owner.
- oMEM_ADDR  out  32  muxed from owner.
- oMEM_DATA  out  32  muxed from owner.
- iMEM_VALID  in  1  memory response.
- iMEM_PAGEFAULT  in  1  response pagefault.
- iMEM_MMU_FLAGS  in  28  response MMU flags.
- iMEM_DATA  in  64  response data.
- oERR_ORPHAN  out  1  sticky flag: a response arrived while the FIFO was empty.

Behaviour:
- **States.** L_PARAM_IDLE, L_PARAM_GRANT_S0, L_PARAM_GRANT_S1; state register is 2 bits. Round-robin pointer b_rr: 0 means S0 has priority.
- **IDLE.**
  - If either REQ is high, move to GRANT_x next cycle. With both high, the winner is chosen by b_rr.
  - Arbitration latency is 1 cycle. No beat is accepted while in IDLE.
- **GRANT_x.**
  - oMEM_REQ = iSx_REQ && !fifo_full.
  - All oMEM_* payload signals are muxed from port x. When not granted, payload is driven to 0.
- **Beat acceptance.** A beat is accepted when oMEM_REQ && !iMEM_LOCK.
  - On accept: push owner bit x into the FIFO and increment the 4-bit beat counter b_beat.
- **Locks.**
  - oSx_LOCK = !(state == GRANT_x) || iMEM_LOCK || fifo_full.
  - The non-owner is always locked.
- **Release.** Evaluated each cycle in GRANT_x. Release happens when:
  - iSx_REQ is low, or
  - an accept makes b_beat reach P_BURST_MAX while the other REQ is high.
- **On release:**
  - If the other REQ is high, go directly to GRANT_other; otherwise go to IDLE.
  - b_rr points to the other port.
  - b_beat clears.
- **Hold at burst limit.** If b_beat reaches P_BURST_MAX with the other REQ low, the grant is held and b_beat clears.
- **Responses.**
  - On iMEM_VALID: pop the FIFO head and combinationally assert oSh_VALID for head owner h in the same cycle. 0-cycle response latency.
  - PAGEFAULT, MMU_FLAGS and DATA are broadcast to both ports unregistered; only VALID is steered.
  - Every accepted beat, reads and writes alike, receives exactly one response, in order.
- **FIFO.**
  - Pointers are log2(P_OUTSTANDING)+1 bits.
  - full: MSBs differ and LSBs are equal. empty: pointers equal.
  - Push and pop in the same cycle are legal when full: the pop frees the entry, the count is unchanged, and no overflow occurs.
  - fifo_full blocks acceptance for that cycle only.
- **Orphan response.** iMEM_VALID with the FIFO empty: no oSx_VALID, no pop, set oERR_ORPHAN. The flag clears only on reset.
- **Reset values.**
  - State: IDLE. b_rr = 0. b_beat = 0. FIFO empty.
  - oSx_LOCK = 1. oMEM_REQ = 0. oSx_VALID = 0. oERR_ORPHAN = 0. All payload outputs = 0.
- **Reset mid-burst.** All outstanding tags are discarded. Responses arriving after reset are orphans.

Optional Feature:
- Macro: L1_MEM_ARB_PERF_COUNTER_EN.
- Defined: adds outputs oPERF_GRANT_S0 [31:0], oPERF_GRANT_S1 [31:0] and oPERF_CONFLICT [31:0].
  - oPERF_GRANT_S0 / oPERF_GRANT_S1 count accepted beats per port.
  - oPERF_CONFLICT counts cycles where the non-owner REQ is high, or both REQs are high in IDLE.
  - Counters are 32 bits, wrap silently, and reset to 0.
- Undefined: the ports are absent and there is no logic.

Decomposition:
- Shared package/header (processor.h scope) holds:
  - state localparams L_PARAM_IDLE, L_PARAM_GRANT_S0, L_PARAM_GRANT_S1;
  - owner encodings L_OWNER_DATA = 0, L_OWNER_INST = 1.
- One sub-module: l1_mem_port_arbiter_tag_fifo. 1-bit wide, depth P_OUTSTANDING, with push/pop/full/empty.

Test Plan:
- **Single burst.** S0 REQ for 8 beats, iMEM_LOCK = 0, no S1 → grant 1 cycle after REQ; 8 beats on consecutive cycles with ADDR = S0 addresses; 8 responses produce oS0_VALID only; oS1_VALID stays 0.
- **Contention.** S0 and S1 both REQ continuously from reset → S0 granted first; after 8 accepts, S1 granted with no IDLE cycle; after S1's 8 accepts, S0 granted again; response VALIDs follow the grant order 8×S0, 8×S1.
- **Memory lock.** iMEM_LOCK = 1 for 5 cycles during GRANT_S1 → oS1_LOCK = 1 for those cycles; no FIFO push; resume with no lost or duplicated beat.
- **FIFO full.** P_OUTSTANDING = 16, 16 accepted beats, no responses → oMEM_REQ = 0 and oS0_LOCK = 1. Then a single iMEM_VALID with REQ held → a beat is accepted in the same cycle as the pop.
- **Orphan response.** iMEM_VALID with the FIFO empty → no oSx_VALID; oERR_ORPHAN = 1 and it stays set until inRESET.
- **Reset mid-burst.** inRESET low after 3 of 8 beats → all outputs return to reset values immediately; oS0_LOCK = 1; FIFO empty.
